// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared FSM state and requester-index constants for ram_arbiter
package ram_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int REQ_R0 = 0;
    localparam int REQ_R1 = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - 2-way grant logic; round-robin pointer only with RAM_ARB_RR_EN, else r0 fixed priority
module rr_arbiter2
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef RAM_ARB_RR_EN
    // ptr_q = 0 means r0 wins the next conflict
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ_R0]) begin
            ptr_d = 1'b1;
        end else if (gnt[REQ_R1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt = req;
        if (req[REQ_R0]) begin
            gnt[REQ_R1] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter with r1 lock; RAM_ARB_RR_EN selects round-robin
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 108,
    parameter int DATA_DEPTH = 800,
    parameter int LOCK_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    input  logic                  r1_lock,
    output logic                  mem_load,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  err_addr,
    output logic                  err_lock
);

    localparam int                    CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]      LOCK_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic                   r0_rvalid_q, r0_rvalid_d;
    logic                   r1_rvalid_q, r1_rvalid_d;
    logic                   rd_in_range_q, rd_in_range_d;
    logic                   err_addr_q, err_addr_d;
    logic                   err_lock_q, err_lock_d;

    logic [1:0]             req;
    logic [1:0]             gnt;
    logic                   sel_we;
    logic                   sel_in_range;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   xfer;

    // Requests are masked during reset so every combinational output reads 0
    assign req[REQ_R0] = r0_valid & (state_q == ST_IDLE) & ~rst;
    assign req[REQ_R1] = r1_valid & ~rst;

    rr_arbiter2 u_arb (
`ifdef RAM_ARB_RR_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (req),
        .gnt (gnt)
    );

    assign r0_ready = gnt[REQ_R0];
    assign r1_ready = gnt[REQ_R1];
    assign xfer     = |gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[REQ_R0]) begin
            sel_we    = r0_we;
            sel_addr  = r0_addr;
            sel_wdata = r0_wdata;
        end else if (gnt[REQ_R1]) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    assign sel_in_range = {1'b0, sel_addr} < DEPTH_L;

    assign mem_load = xfer & sel_we & sel_in_range;
    assign mem_addr = sel_addr;
    assign mem_d    = sel_wdata;

    // Out-of-range reads complete with zero data instead of whatever the RAM returns
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = (r0_rvalid_q & rd_in_range_q) ? mem_q : '0;
    assign r1_rdata  = (r1_rvalid_q & rd_in_range_q) ? mem_q : '0;
    assign err_addr  = err_addr_q;
    assign err_lock  = err_lock_q;

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        err_lock_d    = err_lock_q;
        err_addr_d    = err_addr_q | (xfer & ~sel_in_range);
        r0_rvalid_d   = gnt[REQ_R0] & ~r0_we;
        r1_rvalid_d   = gnt[REQ_R1] & ~r1_we;
        rd_in_range_d = sel_in_range;
        case (state_q)
            ST_IDLE: begin
                if (gnt[REQ_R1] && r1_lock) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                // A timeout always lands in IDLE, even if r1 asks to stay locked
                if (gnt[REQ_R1] && !r1_lock) begin
                    state_d = ST_IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_IDLE;
                    err_lock_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lock_cnt_q    <= '0;
            r0_rvalid_q   <= 1'b0;
            r1_rvalid_q   <= 1'b0;
            rd_in_range_q <= 1'b0;
            err_addr_q    <= 1'b0;
            err_lock_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            r0_rvalid_q   <= r0_rvalid_d;
            r1_rvalid_q   <= r1_rvalid_d;
            rd_in_range_q <= rd_in_range_d;
            err_addr_q    <= err_addr_d;
            err_lock_q    <= err_lock_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - vector table plus read scoreboard for ram_arbiter
module tb_ram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 108;
    localparam int DEPTH = 800;
    localparam int LMAX  = 64;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_ready, r1_we, r1_rvalid, r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          mem_load;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d, mem_q;
    logic          err_addr, err_lock;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .LOCK_MAX   (LMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_lock   (r1_lock),
        .mem_load  (mem_load),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_q     (mem_q),
        .err_addr  (err_addr),
        .err_lock  (err_lock)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return {8'hA5, {(DW-40){1'b0}}, 32'(a)};
    endfunction

    // Read-first synchronous RAM, preloaded with a nonzero pattern during reset
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (mem_load) begin
            mem[mem_addr] <= mem_d;
        end
        mem_q <= mem[mem_addr];
    end

    typedef struct {
        logic          r0v, r0we;
        logic [AW-1:0] r0a;
        logic [DW-1:0] r0d;
        logic          r1v, r1we;
        logic [AW-1:0] r1a;
        logic [DW-1:0] r1d;
        logic          r1lk;
        logic          e0, e1, eld;
    } vec_t;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] ref_mem [0:1023];
    exp_t          sb[$];
    vec_t          vecs[17];
    int            cyc;
    int            passed;
    int            total;

    function automatic vec_t mk(input logic r0v, r0we, input int r0a, input logic [DW-1:0] r0d,
                                input logic r1v, r1we, input int r1a, input logic [DW-1:0] r1d,
                                input logic r1lk, e0, e1, eld);
        vec_t v;
        v.r0v = r0v; v.r0we = r0we; v.r0a = AW'(r0a); v.r0d = r0d;
        v.r1v = r1v; v.r1we = r1we; v.r1a = AW'(r1a); v.r1d = r1d;
        v.r1lk = r1lk; v.e0 = e0; v.e1 = e1; v.eld = eld;
        return v;
    endfunction

    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? ref_mem[a] : '0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input vec_t v);
        r0_valid = v.r0v; r0_we = v.r0we; r0_addr = v.r0a; r0_wdata = v.r0d;
        r1_valid = v.r1v; r1_we = v.r1we; r1_addr = v.r1a; r1_wdata = v.r1d;
        r1_lock  = v.r1lk;
    endtask

    task automatic expect_xfer(input logic who, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        exp_t e;
        if (we) begin
            if (int'(a) < DEPTH) ref_mem[a] = d;
        end else begin
            e.who = who; e.data = ref_val(a); e.due = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic sb_check();
        logic got_any;
        logic due_now;
        exp_t e;
        got_any = r0_rvalid | r1_rvalid;
        due_now = (sb.size() != 0) && (sb[0].due == cyc);
        if (got_any || due_now) begin
            chk("rvalid_timing", DW'(got_any), DW'(due_now));
            if (got_any && due_now) begin
                e = sb.pop_front();
                chk("rvalid_both", DW'(r0_rvalid & r1_rvalid), '0);
                chk("rvalid_who", DW'(r1_rvalid), DW'(e.who));
                chk("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
            end else if (due_now) begin
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic step(input logic e0, input logic e1, input logic eld);
        @(negedge clk);
        sb_check();
        chk("r0_ready", DW'(r0_ready), DW'(e0));
        chk("r1_ready", DW'(r1_ready), DW'(e1));
        chk("mem_load", DW'(mem_load), DW'(eld));
        if (eld) begin
            chk("mem_addr", DW'(mem_addr), DW'(e0 ? r0_addr : r1_addr));
            chk("mem_d", mem_d, e0 ? r0_wdata : r1_wdata);
        end
        if (e0) expect_xfer(1'b0, r0_we, r0_addr, r0_wdata);
        if (e1) expect_xfer(1'b1, r1_we, r1_addr, r1_wdata);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_r0_ready"},  DW'(r0_ready),  '0);
        chk({tag, "_r1_ready"},  DW'(r1_ready),  '0);
        chk({tag, "_r0_rvalid"}, DW'(r0_rvalid), '0);
        chk({tag, "_r1_rvalid"}, DW'(r1_rvalid), '0);
        chk({tag, "_r0_rdata"},  r0_rdata,       '0);
        chk({tag, "_r1_rdata"},  r1_rdata,       '0);
        chk({tag, "_mem_load"},  DW'(mem_load),  '0);
        chk({tag, "_mem_addr"},  DW'(mem_addr),  '0);
        chk({tag, "_mem_d"},     mem_d,          '0);
        chk({tag, "_err_addr"},  DW'(err_addr),  '0);
        chk({tag, "_err_lock"},  DW'(err_lock),  '0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        //              r0v we  addr data       r1v we  addr data      lk  e0     e1     ld
        vecs[0]  = mk(1, 1,   3, 'h5A,    0, 0,   0, 'h0,    0,  1,     0,     1);
        vecs[1]  = mk(1, 0,   3, 'h0,     0, 0,   0, 'h0,    0,  1,     0,     0);
        vecs[2]  = mk(0, 0,   0, 'h0,     0, 0,   0, 'h0,    0,  0,     0,     0);
        vecs[3]  = mk(0, 0,   0, 'h0,     1, 1,   7, 'h77,   0,  0,     1,     1);
        vecs[4]  = mk(1, 0,   3, 'h0,     1, 0,   7, 'h0,    0,  1,     0,     0);
        vecs[5]  = mk(1, 0,   3, 'h0,     1, 0,   7, 'h0,    0,  !RR,   RR,    0);
        vecs[6]  = mk(1, 0,   3, 'h0,     1, 0,   7, 'h0,    0,  1,     0,     0);
        vecs[7]  = mk(1, 0,   3, 'h0,     1, 0,   7, 'h0,    0,  !RR,   RR,    0);
        vecs[8]  = mk(1, 1, 800, 'hDEAD,  0, 0,   0, 'h0,    0,  1,     0,     0);
        vecs[9]  = mk(1, 0, 800, 'h0,     0, 0,   0, 'h0,    0,  1,     0,     0);
        vecs[10] = mk(0, 0,   0, 'h0,     1, 1,  12, 'hC1,   1,  0,     1,     1);
        vecs[11] = mk(1, 0,  12, 'h0,     1, 1,  12, 'hC2,   1,  0,     1,     1);
        vecs[12] = mk(1, 0,  12, 'h0,     1, 1,  12, 'hC3,   1,  0,     1,     1);
        vecs[13] = mk(1, 0,  12, 'h0,     1, 1,  12, 'hC4,   1,  0,     1,     1);
        vecs[14] = mk(1, 0,  12, 'h0,     1, 1,  13, 'hC5,   0,  0,     1,     1);
        vecs[15] = mk(1, 0,  12, 'h0,     0, 0,   0, 'h0,    0,  1,     0,     0);
        vecs[16] = mk(0, 0,   0, 'h0,     0, 0,   0, 'h0,    0,  0,     0,     0);

        rst = 1'b1;
        drive(vecs[16]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            step(vecs[i].e0, vecs[i].e1, vecs[i].eld);
        end
        chk("err_addr_set", DW'(err_addr), DW'(1));
        chk("err_lock_clear", DW'(err_lock), '0);

        // Lock, then let r1 go silent until the timeout releases r0
        drive(mk(0, 0, 0, 'h0, 1, 1, 20, 'hE1, 1, 0, 1, 1));
        step(1'b0, 1'b1, 1'b1);
        chk("err_lock_before_timeout", DW'(err_lock), '0);
        drive(mk(1, 0, 20, 'h0, 0, 0, 0, 'h0, 0, 0, 0, 0));
        for (int i = 0; i < LMAX; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        drive(vecs[16]);
        step(1'b0, 1'b0, 1'b0);
        chk("err_lock_timeout", DW'(err_lock), DW'(1));
        chk("err_addr_sticky", DW'(err_addr), DW'(1));

        // Reset lands while a read is in flight; its rvalid must never appear
        drive(mk(1, 0, 3, 'h0, 0, 0, 0, 'h0, 0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(vecs[16]);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("post_reset_rvalid", DW'(r0_rvalid | r1_rvalid), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
